prim_subreg_shadow: RTL and testbench

PRIM_SUBREG_SHADOW -- requirements
Module: prim_subreg_shadow

---
 rtl/prim_subreg_pkg.sv | 32 +++
 rtl/prim_subreg_arb.sv | 39 +++
 rtl/prim_subreg_shadow.sv | 128 ++++++++++++
 tb/tb_prim_subreg_shadow.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/prim_subreg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prim_subreg_pkg
// Description : Shared register-field types: software access modes and
//               shadow-register phase encoding.
// Revision    : 1.0
// ============================================================================
package prim_subreg_pkg;

    typedef enum logic [2:0] {
        SwAccessRW  = 3'd0,
        SwAccessRO  = 3'd1,
        SwAccessWO  = 3'd2,
        SwAccessW1C = 3'd3,
        SwAccessW1S = 3'd4,
        SwAccessW0C = 3'd5,
        SwAccessRC  = 3'd6
    } sw_access_e;

    typedef enum logic {
        ShadowIdle   = 1'b0,
        ShadowStaged = 1'b1
    } shadow_phase_e;

    // Access modes that make sense for a two-phase shadowed write.
    function automatic logic shadow_access_legal(sw_access_e acc);
        return (acc == SwAccessRW)  || (acc == SwAccessW1S) ||
               (acc == SwAccessW1C) || (acc == SwAccessW0C);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prim_subreg_arb.sv
`default_nettype none
// ============================================================================
// Module      : prim_subreg_arb
// Description : Combines a software write (per access mode) and a hardware
//               write into the next field value; software has priority.
// Revision    : 1.0
// ============================================================================
module prim_subreg_arb
    import prim_subreg_pkg::*;
#(
    parameter int         DW       = 32,
    parameter sw_access_e SwAccess = SwAccessRW
) (
    input  logic          we,
    input  logic [DW-1:0] wd,
    input  logic          de,
    input  logic [DW-1:0] d,
    input  logic [DW-1:0] q,
    output logic          wr_en,
    output logic [DW-1:0] wr_data
);

    logic [DW-1:0] w_sw_data;

    always_comb begin
        w_sw_data = wd;
        case (SwAccess)
            SwAccessW1S: w_sw_data = q | wd;
            SwAccessW1C: w_sw_data = q & ~wd;
            SwAccessW0C: w_sw_data = q & wd;
            default:     w_sw_data = wd;
        endcase
    end

    assign wr_en   = we | de;
    assign wr_data = we ? w_sw_data : d;

endmodule
`default_nettype wire

// File: rtl/prim_subreg_shadow.sv
`default_nettype none
// ============================================================================
// Module      : prim_subreg_shadow
// Description : Shadowed register field: two matching software writes commit,
//               with optional inverted storage copy for fault detection
//               (enabled by PRIM_SUBREG_SHADOW_STORAGE_CHK_EN).
// Revision    : 1.0
// ============================================================================
module prim_subreg_shadow
    import prim_subreg_pkg::*;
#(
    parameter int            DW       = 32,
    parameter sw_access_e    SwAccess = SwAccessRW,
    parameter logic [DW-1:0] RESVAL   = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          re,
    input  logic          we,
    input  logic [DW-1:0] wd,
    input  logic          de,
    input  logic [DW-1:0] d,
    output logic          qe,
    output logic [DW-1:0] q,
    output logic [DW-1:0] qs,
    output logic [DW-1:0] ds,
    output logic          phase_o,
    output logic          err_update,
    output logic          err_storage
);

    generate
        if (!shadow_access_legal(SwAccess)) begin : g_illegal_access
            $error("prim_subreg_shadow: SwAccess must be RW, W1S, W1C or W0C");
        end
    endgenerate

    shadow_phase_e r_phase;
    logic [DW-1:0] r_staged;
    logic [DW-1:0] r_q;
    logic          r_qe;
    logic          r_err_update;

    logic          w_match;
    logic          w_commit;
    logic          w_wr_en;
    logic [DW-1:0] w_wr_data;

    assign w_match  = (wd == r_staged);
    assign w_commit = (r_phase == ShadowStaged) && we && w_match;

    prim_subreg_arb #(
        .DW       (DW),
        .SwAccess (SwAccess)
    ) u_arb (
        .we      (w_commit),
        .wd      (r_staged),
        .de      (de),
        .d       (d),
        .q       (r_q),
        .wr_en   (w_wr_en),
        .wr_data (w_wr_data)
    );

    // Phase sequencing; re only matters when no write is present.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_phase      <= ShadowIdle;
            r_staged     <= RESVAL;
            r_qe         <= 1'b0;
            r_err_update <= 1'b0;
        end else begin
            r_qe         <= 1'b0;
            r_err_update <= 1'b0;
            case (r_phase)
                ShadowIdle: begin
                    if (we) begin
                        r_staged <= wd;
                        r_phase  <= ShadowStaged;
                    end
                end
                ShadowStaged: begin
                    if (we) begin
                        r_phase      <= ShadowIdle;
                        r_qe         <= w_match;
                        r_err_update <= ~w_match;
                    end else if (re) begin
                        r_phase <= ShadowIdle;
                    end
                end
                default: r_phase <= ShadowIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_q <= RESVAL;
        end else if (w_wr_en) begin
            r_q <= w_wr_data;
        end
    end

`ifdef PRIM_SUBREG_SHADOW_STORAGE_CHK_EN
    logic [DW-1:0] r_shadow;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_shadow <= ~RESVAL;
        end else if (w_wr_en) begin
            r_shadow <= ~w_wr_data;
        end
    end

    assign err_storage = (r_q != ~r_shadow);
`else
    assign err_storage = 1'b0;
`endif

    assign q          = r_q;
    assign qs         = r_q;
    assign ds         = r_staged;
    assign qe         = r_qe;
    assign phase_o    = (r_phase == ShadowStaged);
    assign err_update = r_err_update;

endmodule
`default_nettype wire

// File: tb/tb_prim_subreg_shadow.sv
`default_nettype none
// ============================================================================
// Module      : tb_prim_subreg_shadow
// Description : Directed bench for prim_subreg_shadow (RW and W1C instances).
// Revision    : 1.0
// ============================================================================
module tb_prim_subreg_shadow;
    import prim_subreg_pkg::*;

    logic       clk;
    logic       rst;
    logic       re;
    logic       we;
    logic [7:0] wd;
    logic       de;
    logic [7:0] d;

    logic       a_qe, a_phase, a_err_update, a_err_storage;
    logic [7:0] a_q, a_qs, a_ds;
    logic       b_qe, b_phase, b_err_update, b_err_storage;
    logic [7:0] b_q, b_qs, b_ds;

    int n_checks = 0;
    int n_errors = 0;

    prim_subreg_shadow #(.DW(8), .SwAccess(SwAccessRW), .RESVAL(8'h00)) u_a (
        .clk_i(clk), .rst_i(rst), .re(re), .we(we), .wd(wd), .de(de), .d(d),
        .qe(a_qe), .q(a_q), .qs(a_qs), .ds(a_ds), .phase_o(a_phase),
        .err_update(a_err_update), .err_storage(a_err_storage)
    );

    prim_subreg_shadow #(.DW(8), .SwAccess(SwAccessW1C), .RESVAL(8'hC3)) u_b (
        .clk_i(clk), .rst_i(rst), .re(re), .we(we), .wd(wd), .de(de), .d(d),
        .qe(b_qe), .q(b_q), .qs(b_qs), .ds(b_ds), .phase_o(b_phase),
        .err_update(b_err_update), .err_storage(b_err_storage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic i_we, input logic [7:0] i_wd, input logic i_re,
                         input logic i_de, input logic [7:0] i_d);
        we = i_we; wd = i_wd; re = i_re; de = i_de; d = i_d;
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        #3;
        check("rst_a_q", a_q, 8'h00);
        check("rst_a_qs", a_qs, 8'h00);
        check("rst_a_ds", a_ds, 8'h00);
        check("rst_a_phase", a_phase, 1'b0);
        check("rst_a_qe", a_qe, 1'b0);
        check("rst_a_err_update", a_err_update, 1'b0);
        check("rst_a_err_storage", a_err_storage, 1'b0);
        check("rst_b_q", b_q, 8'hC3);
        check("rst_b_ds", b_ds, 8'hC3);
        check("rst_b_err_storage", b_err_storage, 1'b0);
        step();
        rst = 1'b0;

        // Matching double write
        drive(1'b1, 8'h5A, 1'b0, 1'b0, 8'h00); step();
        check("match_p1_phase", a_phase, 1'b1);
        check("match_p1_ds", a_ds, 8'h5A);
        check("match_p1_q", a_q, 8'h00);
        check("match_p1_qe", a_qe, 1'b0);
        step();
        check("match_q", a_q, 8'h5A);
        check("match_qs", a_qs, 8'h5A);
        check("match_qe", a_qe, 1'b1);
        check("match_phase", a_phase, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00); step();
        check("match_qe_drop", a_qe, 1'b0);
        check("match_q_hold", a_q, 8'h5A);

        // Mismatched double write
        do_reset();
        drive(1'b1, 8'h5A, 1'b0, 1'b0, 8'h00); step();
        drive(1'b1, 8'h3C, 1'b0, 1'b0, 8'h00); step();
        check("mism_err_update", a_err_update, 1'b1);
        check("mism_q", a_q, 8'h00);
        check("mism_phase", a_phase, 1'b0);
        check("mism_qe", a_qe, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00); step();
        check("mism_err_drop", a_err_update, 1'b0);

        // Read abort, then a fresh first write
        drive(1'b1, 8'h11, 1'b0, 1'b0, 8'h00); step();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00); step();
        check("abort_phase", a_phase, 1'b0);
        check("abort_ds", a_ds, 8'h11);
        drive(1'b1, 8'h22, 1'b0, 1'b0, 8'h00); step();
        check("abort_rewrite_phase", a_phase, 1'b1);
        check("abort_rewrite_ds", a_ds, 8'h22);
        check("abort_q", a_q, 8'h00);

        // Read in STAGED aborts; a second read in IDLE changes nothing
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00); step();
        step();
        check("re_idle_phase", a_phase, 1'b0);
        check("re_idle_ds", a_ds, 8'h22);
        check("re_idle_q", a_q, 8'h00);

        // we and re together: the write wins
        drive(1'b1, 8'h33, 1'b1, 1'b0, 8'h00); step();
        check("wr_re_p1_phase", a_phase, 1'b1);
        step();
        check("wr_re_q", a_q, 8'h33);
        check("wr_re_qe", a_qe, 1'b1);

        // Hardware write alone
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h44); step();
        check("de_q", a_q, 8'h44);
        check("de_qe", a_qe, 1'b0);
        check("de_err_storage", a_err_storage, 1'b0);

        // Hardware write alongside a first-phase write
        drive(1'b1, 8'h66, 1'b0, 1'b1, 8'h55); step();
        check("de_p1_q", a_q, 8'h55);
        check("de_p1_ds", a_ds, 8'h66);
        check("de_p1_phase", a_phase, 1'b1);
        drive(1'b1, 8'h66, 1'b0, 1'b0, 8'h00); step();
        check("de_p1_commit_q", a_q, 8'h66);

        // Hardware write colliding with a commit
        drive(1'b1, 8'h5A, 1'b0, 1'b0, 8'h00); step();
        drive(1'b1, 8'h5A, 1'b0, 1'b1, 8'h77); step();
        check("collide_q", a_q, 8'h5A);
        check("collide_qe", a_qe, 1'b1);

        // W1C commit against q=0xFF
        do_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'hFF); step();
        check("w1c_pre_q", b_q, 8'hFF);
        drive(1'b1, 8'h0F, 1'b0, 1'b0, 8'h00); step();
        check("w1c_p1_q", b_q, 8'hFF);
        step();
        check("w1c_q", b_q, 8'hF0);
        check("w1c_qe", b_qe, 1'b1);
        check("w1c_rw_q", a_q, 8'h0F);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00); step();
        check("w1c_qe_drop", b_qe, 1'b0);

        // Reset while STAGED
        drive(1'b1, 8'h5A, 1'b0, 1'b0, 8'h00); step();
        check("rst_stg_pre_phase", a_phase, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        #1;
        check("rst_stg_phase", a_phase, 1'b0);
        check("rst_stg_ds", a_ds, 8'h00);
        check("rst_stg_q", a_q, 8'h00);
        check("rst_stg_b_q", b_q, 8'hC3);
        step();
        rst = 1'b0;
        drive(1'b1, 8'hAA, 1'b0, 1'b0, 8'h00); step();
        check("rst_stg_single_phase", a_phase, 1'b1);
        check("rst_stg_single_q", a_q, 8'h00);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00); step();
        check("rst_stg_single_q_hold", a_q, 8'h00);
        check("rst_stg_qe", a_qe, 1'b0);

`ifdef PRIM_SUBREG_SHADOW_STORAGE_CHK_EN
        // Storage fault: shadow of q=0x00 is 0xFF; flip bit 0
        check("stor_pre", a_err_storage, 1'b0);
        force u_a.r_shadow[0] = 1'b0;
        #1;
        check("stor_fault", a_err_storage, 1'b1);
        release u_a.r_shadow[0];
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
